// File: rtl/seven_seg_pkg.sv
// Shared glyph table and nibble-to-segment decode for the seven-segment scanner.
// Segment order is abcdefg, with seg[6] = a and seg[0] = g.
package seven_seg_pkg;

  localparam logic [6:0] GLYPH_0   = 7'b1111110;
  localparam logic [6:0] GLYPH_1   = 7'b0110000;
  localparam logic [6:0] GLYPH_2   = 7'b1101101;
  localparam logic [6:0] GLYPH_3   = 7'b1111001;
  localparam logic [6:0] GLYPH_4   = 7'b0110011;
  localparam logic [6:0] GLYPH_5   = 7'b1011011;
  localparam logic [6:0] GLYPH_6   = 7'b1011111;
  localparam logic [6:0] GLYPH_7   = 7'b1110000;
  localparam logic [6:0] GLYPH_8   = 7'b1111111;
  localparam logic [6:0] GLYPH_9   = 7'b1111011;
  localparam logic [6:0] GLYPH_A   = 7'b1110111;
  localparam logic [6:0] GLYPH_B   = 7'b0011111;
  localparam logic [6:0] GLYPH_C   = 7'b1001110;
  localparam logic [6:0] GLYPH_D   = 7'b0111101;
  localparam logic [6:0] GLYPH_E   = 7'b1001111;
  localparam logic [6:0] GLYPH_F   = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // In BCD mode, codes above 9 have no glyph and are shown blank.
  function automatic logic [6:0] decode_glyph(input logic [3:0] nibble, input logic hex_mode);
    logic [6:0] glyph;
    case (nibble)
      4'h0:    glyph = GLYPH_0;
      4'h1:    glyph = GLYPH_1;
      4'h2:    glyph = GLYPH_2;
      4'h3:    glyph = GLYPH_3;
      4'h4:    glyph = GLYPH_4;
      4'h5:    glyph = GLYPH_5;
      4'h6:    glyph = GLYPH_6;
      4'h7:    glyph = GLYPH_7;
      4'h8:    glyph = GLYPH_8;
      4'h9:    glyph = GLYPH_9;
      4'hA:    glyph = GLYPH_A;
      4'hB:    glyph = GLYPH_B;
      4'hC:    glyph = GLYPH_C;
      4'hD:    glyph = GLYPH_D;
      4'hE:    glyph = GLYPH_E;
      default: glyph = GLYPH_F;
    endcase
    if (!hex_mode && nibble > 4'd9) glyph = SEG_BLANK;
    return glyph;
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational nibble-to-glyph decoder.
// The output is active-high; polarity is applied by the scanner.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [6:0] glyph
);

  assign glyph = decode_glyph(nibble, hex_mode);

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scanner with frame-aligned display updates.
// A new value is held in a shadow register and moves to the display only at a frame boundary.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    hex_mode,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int PW = $clog2(PRESCALE + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0]            SEG_INV = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] EN_INV  = {NUM_DIGITS{SEG_ACTIVE_LOW}};

  logic [PW-1:0]             presc_cnt;
  logic [IW-1:0]             idx;
  logic                      tick;
  logic                      frame_edge;
  logic [4*NUM_DIGITS-1:0]   shadow_value;
  logic [NUM_DIGITS-1:0]     shadow_dp;
  logic [4*NUM_DIGITS-1:0]   disp_value;
  logic [NUM_DIGITS-1:0]     disp_dp;
  logic                      pending;
  logic [3:0]                cur_nibble;
  logic                      cur_dp;
  logic [NUM_DIGITS-1:0]     cur_onehot;
  logic [6:0]                cur_glyph;

  assign tick       = (presc_cnt == PW'(PRESCALE - 1));
  assign frame_edge = tick && (idx == IW'(NUM_DIGITS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      idx       <= '0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  // A load on the boundary cycle bypasses the shadow so it lands in the very next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_value <= '0;
      shadow_dp    <= '0;
      disp_value   <= '0;
      disp_dp      <= '0;
      pending      <= 1'b0;
    end else begin
      if (load) begin
        shadow_value <= value;
        shadow_dp    <= dp_in;
      end
      if (frame_edge) begin
        pending <= 1'b0;
        if (load) begin
          disp_value <= value;
          disp_dp    <= dp_in;
        end else if (pending) begin
          disp_value <= shadow_value;
          disp_dp    <= shadow_dp;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cur_nibble = '0;
    cur_dp     = 1'b0;
    cur_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nibble    = disp_value[4*i +: 4];
        cur_dp        = disp_dp[i];
        cur_onehot[i] = 1'b1;
      end
    end
  end

  seven_seg_decode u_decode (
    .nibble   (cur_nibble),
    .hex_mode (hex_mode),
    .glyph    (cur_glyph)
  );

  // Output registers hold physical pin levels; reset leaves every pin at its inactive level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_INV;
      dp         <= SEG_ACTIVE_LOW;
      digit_en   <= EN_INV;
      frame_done <= 1'b0;
    end else begin
      seg        <= cur_glyph ^ SEG_INV;
      dp         <= cur_dp ^ SEG_ACTIVE_LOW;
      digit_en   <= cur_onehot ^ EN_INV;
      frame_done <= frame_edge;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: 4 digits, 4 clocks per digit slot.
// A second instance with inverted outputs shares all inputs.
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        hex_mode = 1'b0;
  logic [6:0]  seg, seg_al;
  logic        dp, dp_al;
  logic [3:0]  digit_en, digit_en_al;
  logic        frame_done, frame_done_al;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  seven_seg_scan #(.NUM_DIGITS(4), .PRESCALE(4), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .hex_mode(hex_mode), .seg(seg), .dp(dp), .digit_en(digit_en),
    .frame_done(frame_done)
  );

  seven_seg_scan #(.NUM_DIGITS(4), .PRESCALE(4), .SEG_ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .hex_mode(hex_mode), .seg(seg_al), .dp(dp_al), .digit_en(digit_en_al),
    .frame_done(frame_done_al)
  );

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic            hex;
    logic [3:0][6:0] seg;   // seg[k] is the glyph expected on digit k
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    step(1);
    load  = 1'b0;
  endtask

  // Returns just after the edge on which frame_done rises.
  task automatic wait_fd();
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (n < 64 && !got) begin
      step(1);
      if (frame_done) got = 1'b1;
      n++;
    end
    if (!got) check("frame_done_timeout", 32'd0, 32'd1);
  endtask

  // Called right after a frame_done edge; samples the first cycle of each digit slot.
  task automatic read_frame(input string tag, input logic [3:0][6:0] exp_seg, input logic [3:0] exp_dp);
    step(1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_en%0d", tag, k), 32'(digit_en), 32'(4'b0001 << k));
      check($sformatf("%s_seg%0d", tag, k), 32'(seg), 32'(exp_seg[k]));
      check($sformatf("%s_dp%0d", tag, k), 32'(dp), 32'(exp_dp[k]));
      if (k < 3) step(4);
    end
  endtask

  initial begin
    logic [3:0] exp_en;
    bit seen1;
    bit got;
    int n;

    vecs[0] = '{16'h3210, 4'b0101, 1'b1, {7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110}};
    vecs[1] = '{16'h7654, 4'b1010, 1'b1, {7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011}};
    vecs[2] = '{16'hBA98, 4'b0000, 1'b1, {7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111}};
    vecs[3] = '{16'hFEDC, 4'b1111, 1'b1, {7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110}};
    vecs[4] = '{16'hFEDC, 4'b0000, 1'b0, {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000}};
    vecs[5] = '{16'hFAB9, 4'b1000, 1'b0, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111011}};

    // Reset state on both polarities
    step(2);
    check("rst_seg", 32'(seg), 32'h00);
    check("rst_en", 32'(digit_en), 32'h0);
    check("rst_fd", 32'(frame_done), 32'h0);
    check("rst_al_seg", 32'(seg_al), 32'h7F);
    check("rst_al_en", 32'(digit_en_al), 32'hF);
    check("rst_al_dp", 32'(dp_al), 32'h1);

    // Scan sequence after reset release
    rst_n = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      step(1);
      exp_en = 4'b0001 << (((c - 1) / 4) % 4);
      check($sformatf("scan_en_c%0d", c), 32'(digit_en), 32'(exp_en));
      check($sformatf("scan_fd_c%0d", c), 32'(frame_done), 32'((c % 16) == 0));
      if (c == 1) begin
        check("first_seg", 32'(seg), 32'(7'b1111110));
        check("first_al_en", 32'(digit_en_al), 32'(4'b1110));
      end
    end

    // Mid-frame load: old digits hold until the boundary
    hex_mode = 1'b1;
    wait_fd();
    step(5);
    do_load(16'h1234, 4'b0000);
    step(3);
    check("hold_seg2", 32'(seg), 32'(7'b1111110));
    check("hold_en2", 32'(digit_en), 32'(4'b0100));
    step(4);
    check("hold_seg3", 32'(seg), 32'(7'b1111110));
    wait_fd();
    read_frame("v1234", {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}, 4'b0000);

    // Glyph table vectors
    for (int i = 0; i < 6; i++) begin
      wait_fd();
      step(5);
      hex_mode = vecs[i].hex;
      do_load(vecs[i].value, vecs[i].dp);
      wait_fd();
      read_frame($sformatf("vec%0d", i), vecs[i].seg, vecs[i].dp);
    end

    // hex_mode switch takes effect on the next cycle, digit 3 of 0xFAB9 still on
    hex_mode = 1'b1;
    step(1);
    check("hexsw_en", 32'(digit_en), 32'(4'b1000));
    check("hexsw_seg", 32'(seg), 32'(7'b1000111));
    hex_mode = 1'b0;
    step(1);
    check("hexsw_back_seg", 32'(seg), 32'(7'b0000000));

    // Two loads in one frame: only the last is ever displayed
    wait_fd();
    step(3);
    do_load(16'h1111, 4'b0000);
    step(3);
    do_load(16'h2222, 4'b0000);
    seen1 = 1'b0;
    got = 1'b0;
    n = 0;
    while (n < 32 && !got) begin
      step(1);
      if (seg == 7'b0110000) seen1 = 1'b1;
      if (frame_done) got = 1'b1;
      n++;
    end
    check("dbl_fd_seen", 32'(got), 32'd1);
    check("dbl_no_1111", 32'(seen1), 32'd0);
    read_frame("v2222", {4{7'b1101101}}, 4'b0000);

    // Load on the boundary tick goes straight to the display
    step(2);
    value = 16'h5678;
    dp_in = 4'b0011;
    load  = 1'b1;
    step(1);
    load  = 1'b0;
    check("coinc_fd", 32'(frame_done), 32'd1);
    check("coinc_pending", 32'(dut.pending), 32'd0);
    read_frame("v5678", {7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111}, 4'b0011);

    // Asynchronous reset mid-frame drops a pending load
    wait_fd();
    step(5);
    do_load(16'h9999, 4'b0000);
    step(1);
    check("pre_rst_pending", 32'(dut.pending), 32'd1);
    check("pre_rst_al_en", 32'(digit_en_al), 32'(4'b1101));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_al_seg", 32'(seg_al), 32'h7F);
    check("arst_al_dp", 32'(dp_al), 32'h1);
    check("arst_al_en", 32'(digit_en_al), 32'hF);
    check("arst_en", 32'(digit_en), 32'h0);
    check("arst_pending", 32'(dut.pending), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    check("rel_al_en", 32'(digit_en_al), 32'(4'b1110));
    check("rel_al_seg", 32'(seg_al), 32'(7'b0000001));
    check("rel_seg", 32'(seg), 32'(7'b1111110));
    wait_fd();
    read_frame("after_rst", {4{7'b1111110}}, 4'b0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of digits scanned (range 1..8).
REQ-002 The block SHALL have parameter PRESCALE, default 1000, giving clk cycles per digit slot (range >= 1).
REQ-003 The block SHALL have parameter SEG_ACTIVE_LOW, default 0; when 1, seg, dp and digit_en are inverted at the outputs.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have port clk  in  1  system clock, rising edge.
REQ-006 The block SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 The block SHALL have port load  in  1  strobe that captures value and dp_in.
REQ-008 The block SHALL have port value  in  4*NUM_DIGITS  nibbles, where digit i = value[4i+3:4i].
REQ-009 The block SHALL have port dp_in  in  NUM_DIGITS  decimal point per digit.
REQ-010 The block SHALL have port hex_mode  in  1  glyph mode: 1 = hex A-F glyphs, 0 = BCD with codes 10-15 blanked.
REQ-011 The block SHALL have port seg  out  7  segments, seg[6]=a ... seg[0]=g, registered.
REQ-012 The block SHALL have port dp  out  1  decimal point of the active digit, registered.
REQ-013 The block SHALL have port digit_en  out  NUM_DIGITS  one-hot digit select, registered.
REQ-014 The block SHALL have port frame_done  out  1  one-cycle pulse at the end of each full scan.

Function
REQ-015 The prescaler SHALL count 0..PRESCALE-1 and wrap, asserting an internal tick while at PRESCALE-1.
REQ-016 On tick, the digit index SHALL advance by 1, wrapping from NUM_DIGITS-1 to 0; otherwise it holds.
REQ-017 Each cycle, seg/dp/digit_en SHALL register the decode of the displayed nibble, the displayed dp bit, and the one-hot encoding of the current index, giving 1-cycle latency from the index to the outputs.
REQ-018 The glyphs (abcdefg) SHALL be: 0 1111110, 1 0110000, 2 1101101, 3 1111001, 4 0110011, 5 1011011, 6 1011111, 7 1110000, 8 1111111, 9 1111011, A 1110111, b 0011111, C 1001110, d 0111101, E 1001111, F 1000111.
REQ-019 In BCD mode, codes 10-15 SHALL produce seg = 0000000; dp is unaffected.
REQ-020 load SHALL capture value and dp_in into a shadow register and set a pending flag; a second load before transfer overwrites the shadow (last wins).
REQ-021 A frame boundary is a tick with index = NUM_DIGITS-1; at a frame boundary, frame_done SHALL pulse high for exactly one cycle.
REQ-022 If pending is set at a frame boundary, the display register SHALL take the shadow contents and pending SHALL clear, so no frame mixes old and new digits.
REQ-023 If load coincides with a frame boundary, the display register SHALL take the load-cycle value and dp_in directly and pending SHALL end clear.
REQ-024 hex_mode SHALL take effect immediately, without frame alignment.
REQ-025 With NUM_DIGITS = 1, every tick SHALL be a frame boundary; with PRESCALE = 1, every cycle SHALL be a tick.

Reset
REQ-026 While rst_n is low, the block SHALL clear the prescaler, index, shadow, display register, pending, seg, dp, digit_en and frame_done to 0; the outputs are at inactive polarity per SEG_ACTIVE_LOW.
REQ-027 On the first clk edge after rst_n deasserts, the block SHALL drive digit_en = ...0001 and seg = 1111110 (glyph 0).
REQ-028 Reset asserted mid-frame SHALL discard any pending load.

Structure
REQ-029 The package seven_seg_pkg SHALL hold the 16 glyph constants, the blank constant and the decode function.
REQ-030 The block SHALL instantiate one combinational sub-module, seven_seg_decode (nibble, hex_mode -> 7-bit glyph).
REQ-031 The prescaler width SHALL be $clog2(PRESCALE+1) and the index width SHALL be max(1, $clog2(NUM_DIGITS)).

Verification
REQ-032 Bench SHALL check reset release with PRESCALE=4, NUM_DIGITS=4: digit_en 0001, 0010, 0100, 1000, 0001 at 4-cycle spacing, with frame_done pulsing once every 16 cycles.
REQ-033 Bench SHALL check load value=16'h1234 mid-frame: the old digits hold until the boundary, then the next frame shows seg 0110011, 1111001, 1101101, 0110000 for digits 0..3.
REQ-034 Bench SHALL check load 16'hFAB9 with hex_mode=0: digits 3..1 blank and digit 0 = 1111011; with hex_mode=1 the next cycle, digit 3 = 1000111.
REQ-035 Bench SHALL check two loads in one frame (0x1111, then 0x2222): only 0x2222 is ever displayed.
REQ-036 Bench SHALL check load coincident with the boundary tick: the new value appears in the very next frame and pending is 0.
REQ-037 Bench SHALL check SEG_ACTIVE_LOW=1 with rst_n pulsed low mid-frame: the outputs go all-ones asynchronously and the pending load is lost.
